uart_tx_buffered: RTL and testbench

//   Parametrised UART transmitter with an input FIFO, programmable bit period, and optional parity and second stop bit.

---
 rtl/uart_tx_buffered_if.sv | 32 +++
 rtl/uart_tx_buffered.sv | 150 +++++++++++++++
 tb/tb_uart_tx_buffered.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_buffered_if.sv
// Producer-side and line-side signals of the buffered UART transmitter.
// The producer owns data, valid and frame config; the transmitter owns the rest.
interface uart_tx_buffered_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int PRESCALE_WIDTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0]     TX_Parallel_Data;
  logic                      TX_Data_Valid;
  logic                      TX_Ready;
  logic                      TX_Parity_Enable;
  logic                      TX_Parity_Type;
  logic                      TX_Stop_Bits;
  logic [PRESCALE_WIDTH-1:0] TX_Prescale;
  logic                      TX_OUT;
  logic                      TX_Busy;
  logic [CNT_W-1:0]          TX_FIFO_Count;

  modport master (
    output TX_Parallel_Data, TX_Data_Valid, TX_Parity_Enable, TX_Parity_Type,
           TX_Stop_Bits, TX_Prescale,
    input  TX_Ready, TX_OUT, TX_Busy, TX_FIFO_Count
  );

  modport slave (
    input  TX_Parallel_Data, TX_Data_Valid, TX_Parity_Enable, TX_Parity_Type,
           TX_Stop_Bits, TX_Prescale,
    output TX_Ready, TX_OUT, TX_Busy, TX_FIFO_Count
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// UART transmitter with an input FIFO, programmable bit period and optional
// parity / second stop bit; queued words are sent back-to-back, LSB first.
module uart_tx_buffered #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int PRESCALE_WIDTH = 8
) (
  input logic               TX_CLK,
  input logic               TX_RST,
  uart_tx_buffered_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  logic [DATA_WIDTH-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          count;
  logic                      push, pop;
  logic [DATA_WIDTH-1:0]     head;

  state_t                    state, state_next;
  logic [PRESCALE_WIDTH-1:0] presc_cnt, presc_next, period;
  logic [BIT_W-1:0]          bit_cnt, bit_next;
  logic [DATA_WIDTH-1:0]     shreg, shreg_next;
  logic                      parity_bit, par_en, two_stop;
  logic                      tx_out, tx_next, busy, busy_next;
  logic                      period_end;

  assign head                = mem[rd_ptr];
  assign bus.TX_Ready        = (count != CNT_W'(FIFO_DEPTH));
  assign push                = bus.TX_Data_Valid && bus.TX_Ready;
  assign period_end          = (presc_cnt == period - PRESCALE_WIDTH'(1));
  assign bus.TX_OUT          = tx_out;
  assign bus.TX_Busy         = busy;
  assign bus.TX_FIFO_Count   = count;

  // NOTE: storage has no reset; emptiness is tracked by the pointers and count,
  // so clearing the array would only cost a reset net on every bit.
  always_ff @(posedge TX_CLK) begin
    if (push) mem[wr_ptr] <= bus.TX_Parallel_Data;
  end

  // NOTE: every write in a clocked block is non-blocking so all registers
  // update from the same pre-edge values.
  always_ff @(posedge TX_CLK) begin
    if (!TX_RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= IDLE;
      presc_cnt <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
      parity_bit <= 1'b0;
      par_en    <= 1'b0;
      two_stop  <= 1'b0;
      period    <= PRESCALE_WIDTH'(1);
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count + CNT_W'(push) - CNT_W'(pop);
      state     <= state_next;
      presc_cnt <= presc_next;
      bit_cnt   <= bit_next;
      shreg     <= shreg_next;
      tx_out    <= tx_next;
      busy      <= busy_next;
      // Frame configuration is frozen for the whole frame at the moment of pop.
      if (pop) begin
        parity_bit <= (^head) ^ bus.TX_Parity_Type;
        par_en     <= bus.TX_Parity_Enable;
        two_stop   <= bus.TX_Stop_Bits;
        period     <= (bus.TX_Prescale == '0) ? PRESCALE_WIDTH'(1) : bus.TX_Prescale;
      end
    end
  end

  // NOTE: every output of this block gets a default first, which keeps the
  // case arms short and rules out latches.
  always_comb begin
    state_next = state;
    bit_next   = bit_cnt;
    shreg_next = shreg;
    tx_next    = tx_out;
    busy_next  = busy;
    pop        = 1'b0;
    presc_next = '0;
    if (state != IDLE && !period_end) presc_next = presc_cnt + PRESCALE_WIDTH'(1);

    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          shreg_next = head;
          state_next = START;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
        end
      end
      START: begin
        if (period_end) begin
          state_next = DATA;
          bit_next   = '0;
          tx_next    = shreg[0];
          shreg_next = shreg >> 1;
        end
      end
      DATA: begin
        if (period_end) begin
          if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
            state_next = par_en ? PARITY : STOP1;
            tx_next    = par_en ? parity_bit : 1'b1;
          end else begin
            bit_next   = bit_cnt + BIT_W'(1);
            tx_next    = shreg[0];
            shreg_next = shreg >> 1;
          end
        end
      end
      PARITY: begin
        if (period_end) begin
          state_next = STOP1;
          tx_next    = 1'b1;
        end
      end
      STOP1, STOP2: begin
        if (period_end) begin
          if (state == STOP1 && two_stop) begin
            state_next = STOP2;
          end else if (count != '0) begin
            // Chain straight into the next start bit with no idle cycle.
            pop        = 1'b1;
            shreg_next = head;
            state_next = START;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            busy_next  = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a scoreboard queue of expected frames is filled
// at push time and a line monitor checks every serial clock against it.
module tb_uart_tx_buffered;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int PW    = 8;

  logic tx_clk = 1'b0;
  logic tx_rst = 1'b0;
  always #5 tx_clk = ~tx_clk;

  uart_tx_buffered_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PRESCALE_WIDTH(PW)) bus ();

  uart_tx_buffered #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PRESCALE_WIDTH(PW)) dut (
    .TX_CLK (tx_clk),
    .TX_RST (tx_rst),
    .bus    (bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    bit            pe;
    bit            pt;
    bit            sb;
    int            p;
  } frame_t;

  frame_t sb_q[$];
  int     tests_run    = 0;
  int     tests_failed = 0;
  bit     mon_en        = 1'b0;
  bit     mon_abort     = 1'b0;
  bit     in_frame      = 1'b0;
  bit     expect_contig = 1'b0;
  int     wait_cnt      = 0;

  function automatic logic [15:0] frame_bits(input frame_t f);
    logic [15:0] b;
    b    = '1;
    b[0] = 1'b0;
    for (int i = 0; i < DW; i++) b[i+1] = f.data[i];
    if (f.pe) b[DW+1] = (^f.data) ^ f.pt;
    return b;
  endfunction

  // Line monitor: one comparison per clock, sampled 1 time unit after the edge.
  initial begin
    frame_t      cur;
    logic [15:0] bits;
    int          nbits;
    int          idx;
    logic        exp_bit;
    cur   = '{data: '0, pe: 1'b0, pt: 1'b0, sb: 1'b0, p: 1};
    bits  = '1;
    nbits = 0;
    idx   = 0;
    forever begin
      @(posedge tx_clk);
      #1;
      if (!mon_en) continue;
      if (mon_abort) begin
        sb_q.delete();
        in_frame      = 1'b0;
        expect_contig = 1'b0;
        wait_cnt      = 0;
        continue;
      end
      if (!in_frame && sb_q.size() > 0 && (bus.TX_OUT === 1'b0 || expect_contig)) begin
        cur           = sb_q.pop_front();
        bits          = frame_bits(cur);
        nbits         = 2 + DW + int'(cur.pe) + int'(cur.sb);
        idx           = 0;
        in_frame      = 1'b1;
        expect_contig = 1'b0;
        wait_cnt      = 0;
      end
      if (in_frame) begin
        exp_bit = bits[idx / cur.p];
        tests_run++;
        if (bus.TX_OUT !== exp_bit || bus.TX_Busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL frame_bit data=%h clk=%0d: got tx=%b busy=%b, want tx=%b busy=1",
                   cur.data, idx, bus.TX_OUT, bus.TX_Busy, exp_bit);
        end
        idx++;
        if (idx == nbits * cur.p) begin
          in_frame      = 1'b0;
          expect_contig = (sb_q.size() > 0);
        end
      end else begin
        tests_run++;
        if (bus.TX_OUT !== 1'b1 || bus.TX_Busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL idle_line: got tx=%b busy=%b, want tx=1 busy=0", bus.TX_OUT, bus.TX_Busy);
        end
        if (sb_q.size() > 0) begin
          wait_cnt++;
          tests_run++;
          if (wait_cnt > 1) begin
            tests_failed++;
            $display("FAIL start_latency: got %0d idle samples with a word queued, want at most 1", wait_cnt);
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000, want finish earlier");
    $fatal(1, "watchdog expired");
  end

  task automatic set_cfg(input bit pe, input bit pt, input bit sb, input int p);
    bus.TX_Parity_Enable = pe;
    bus.TX_Parity_Type   = pt;
    bus.TX_Stop_Bits     = sb;
    bus.TX_Prescale      = PW'(p);
  endtask

  task automatic sb_push(input logic [DW-1:0] d);
    frame_t f;
    f.data = d;
    f.pe   = bus.TX_Parity_Enable;
    f.pt   = bus.TX_Parity_Type;
    f.sb   = bus.TX_Stop_Bits;
    f.p    = (bus.TX_Prescale == '0) ? 1 : int'(bus.TX_Prescale);
    sb_q.push_back(f);
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    @(negedge tx_clk);
    bus.TX_Parallel_Data = d;
    bus.TX_Data_Valid    = 1'b1;
    tests_run++;
    if (bus.TX_Ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL push_ready: got ready=%b, want 1", bus.TX_Ready);
    end else begin
      sb_push(d);
    end
    @(negedge tx_clk);
    bus.TX_Data_Valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while ((sb_q.size() != 0 || in_frame || expect_contig) && cyc < 2000) begin
      @(negedge tx_clk);
      cyc++;
    end
    tests_run++;
    if (cyc >= 2000) begin
      tests_failed++;
      $display("FAIL %s_drain: got %0d frames still pending, want 0", name, sb_q.size());
    end
    repeat (3) @(negedge tx_clk);
  endtask

  task automatic test_reset();
    tx_rst = 1'b0;
    repeat (2) @(posedge tx_clk);
    #1;
    tests_run++;
    if (bus.TX_OUT !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_tx_out: got %b, want 1", bus.TX_OUT);
    end
    tests_run++;
    if (bus.TX_Busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy: got %b, want 0", bus.TX_Busy);
    end
    tests_run++;
    if (bus.TX_FIFO_Count !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_count: got %0d, want 0", bus.TX_FIFO_Count);
    end
    tests_run++;
    if (bus.TX_Ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b, want 1", bus.TX_Ready);
    end
    @(negedge tx_clk);
    tx_rst = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge tx_clk);
  endtask

  task automatic test_basic();
    set_cfg(1'b0, 1'b0, 1'b0, 1);
    push_word(8'hE7);
    @(posedge tx_clk);
    #1;
    tests_run++;
    if (bus.TX_OUT !== 1'b0 || bus.TX_Busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_latency: got tx=%b busy=%b one edge after push, want tx=0 busy=1",
               bus.TX_OUT, bus.TX_Busy);
    end
    tests_run++;
    if (bus.TX_FIFO_Count !== 3'd0) begin
      tests_failed++;
      $display("FAIL basic_popped: got count=%0d, want 0", bus.TX_FIFO_Count);
    end
    wait_idle("basic");
  endtask

  task automatic test_parity();
    set_cfg(1'b1, 1'b1, 1'b0, 1);
    push_word(8'hE7);
    wait_idle("parity_odd");
    set_cfg(1'b1, 1'b0, 1'b0, 1);
    push_word(8'hE7);
    wait_idle("parity_even");
    push_word(8'h38);
    wait_idle("parity_even_38");
  endtask

  task automatic test_long_frame();
    set_cfg(1'b0, 1'b0, 1'b1, 4);
    push_word(8'h00);
    wait_idle("long_frame");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] words [6];
    int k, cyc, stalls;
    words  = '{8'h11, 8'h22, 8'h44, 8'h88, 8'hA5, 8'h5A};
    k      = 0;
    cyc    = 0;
    stalls = 0;
    set_cfg(1'b0, 1'b0, 1'b0, 1);
    while (k < 6 && cyc < 200) begin
      @(negedge tx_clk);
      cyc++;
      bus.TX_Parallel_Data = words[k];
      bus.TX_Data_Valid    = 1'b1;
      if (bus.TX_Ready) begin
        sb_push(words[k]);
        k++;
      end else begin
        stalls++;
        tests_run++;
        if (bus.TX_FIFO_Count !== 3'(DEPTH)) begin
          tests_failed++;
          $display("FAIL b2b_full_count: got %0d with ready low, want %0d", bus.TX_FIFO_Count, DEPTH);
        end
      end
    end
    @(negedge tx_clk);
    bus.TX_Data_Valid = 1'b0;
    tests_run++;
    if (k != 6) begin
      tests_failed++;
      $display("FAIL b2b_accepted: got %0d words accepted, want 6", k);
    end
    tests_run++;
    if (stalls == 0) begin
      tests_failed++;
      $display("FAIL b2b_backpressure: got %0d stall cycles, want at least 1", stalls);
    end
    wait_idle("back_to_back");
  endtask

  task automatic test_config_change();
    set_cfg(1'b0, 1'b0, 1'b0, 3);
    push_word(8'hA5);
    repeat (4) @(negedge tx_clk);
    set_cfg(1'b1, 1'b1, 1'b0, 0);
    push_word(8'h3C);
    wait_idle("config_change");
  endtask

  task automatic test_reset_mid_frame();
    set_cfg(1'b0, 1'b0, 1'b0, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge tx_clk);
      bus.TX_Parallel_Data = DW'(8'hC1 + i);
      bus.TX_Data_Valid    = 1'b1;
      sb_push(DW'(8'hC1 + i));
    end
    @(negedge tx_clk);
    bus.TX_Data_Valid = 1'b0;
    tests_run++;
    if (bus.TX_FIFO_Count !== 3'd2) begin
      tests_failed++;
      $display("FAIL rst_mid_queued: got count=%0d, want 2", bus.TX_FIFO_Count);
    end
    repeat (2) @(negedge tx_clk);
    tx_rst    = 1'b0;
    mon_abort = 1'b1;
    @(posedge tx_clk);
    #1;
    tests_run++;
    if (bus.TX_OUT !== 1'b1 || bus.TX_Busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_line: got tx=%b busy=%b, want tx=1 busy=0", bus.TX_OUT, bus.TX_Busy);
    end
    tests_run++;
    if (bus.TX_FIFO_Count !== 3'd0 || bus.TX_Ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_fifo: got count=%0d ready=%b, want count=0 ready=1",
               bus.TX_FIFO_Count, bus.TX_Ready);
    end
    @(negedge tx_clk);
    tx_rst = 1'b1;
    @(negedge tx_clk);
    mon_abort = 1'b0;
    repeat (40) @(negedge tx_clk);
    tests_run++;
    if (bus.TX_Busy !== 1'b0 || bus.TX_FIFO_Count !== 3'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_quiet: got busy=%b count=%0d, want busy=0 count=0",
               bus.TX_Busy, bus.TX_FIFO_Count);
    end
  endtask

  initial begin
    bus.TX_Parallel_Data = '0;
    bus.TX_Data_Valid    = 1'b0;
    set_cfg(1'b0, 1'b0, 1'b0, 1);
    test_reset();
    test_basic();
    test_parity();
    test_long_frame();
    test_back_to_back();
    test_config_change();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
